// File: rtl/hash_writeback.sv
// Writes a captured Keccak digest to on-chip memory as BEATS bus beats.
// Consecutive digests land in consecutive HASH_W/8-byte slots above base_addr.
module hash_writeback #(
  parameter int DATA_W = 128,
  parameter int HASH_W = 512,
  parameter int BEATS  = HASH_W / DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HASH_W-1:0] hash_in,
  input  logic              hash_valid,
  output logic              hash_ready,
  input  logic [31:0]       base_addr,
  output logic [31:0]       write_addr_offset,
  output logic [DATA_W-1:0] ocm_data_in,
  output logic              bus_write_valid,
  input  logic              bus_write_ready,
  output logic              bus_write_last,
  output logic              done,
  output logic [15:0]       hash_count
);

  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOT_B = HASH_W / 8;
  localparam int BEAT_B = DATA_W / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HASH_W-1:0]   hash_buf_q, hash_buf_d;
  logic [31:0]         base_buf_q, base_buf_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [15:0]         hash_count_q, hash_count_d;

  // Next-state: capture on accept, advance beats on transfer, count on DONE
  always_comb begin
    state_d      = state_q;
    hash_buf_d   = hash_buf_q;
    base_buf_d   = base_buf_q;
    beat_cnt_d   = beat_cnt_q;
    hash_count_d = hash_count_q;
    case (state_q)
      IDLE: begin
        if (hash_valid) begin
          hash_buf_d = hash_in;
          base_buf_d = base_addr;
          beat_cnt_d = '0;
          state_d    = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus_write_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      DONE: begin
        hash_count_d = hash_count_q + 16'd1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hash_buf_q   <= '0;
      base_buf_q   <= 32'd0;
      beat_cnt_q   <= '0;
      hash_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      hash_buf_q   <= hash_buf_d;
      base_buf_q   <= base_buf_d;
      beat_cnt_q   <= beat_cnt_d;
      hash_count_q <= hash_count_d;
    end
  end

  // Outputs decode only registered state, so bus_write_ready/hash_valid never reach them
  assign hash_ready        = (state_q == IDLE);
  assign bus_write_valid   = (state_q == SEND);
  assign done              = (state_q == DONE);
  assign bus_write_last    = (state_q == SEND) && (beat_cnt_q == LAST_BEAT);
  assign ocm_data_in       = hash_buf_q[DATA_W*beat_cnt_q +: DATA_W];
  assign write_addr_offset = base_buf_q + 32'(hash_count_q) * 32'(SLOT_B)
                             + 32'(beat_cnt_q) * 32'(BEAT_B);
  assign hash_count        = hash_count_q;

endmodule

// File: doc/hash_writeback.md
# hash_writeback

Write-side counterpart of the SHA3 burst master's OCM read path: it accepts a completed 512-bit Keccak digest, slices it into four 128-bit beats and writes them to on-chip memory over the 128-bit bus write handshake. Consecutive digests go to consecutive 64-byte slots above a programmable base address. It sits between the Keccak core's hash register and the bus master's write channel.

## Interface
- DATA_W, 128, bus write data width in bits
- HASH_W, 512, digest width in bits; must be a multiple of DATA_W
- BEATS, HASH_W/DATA_W (4), beats per digest
- clk  input  1  clock; all logic is rising-edge
- reset  input  1  reset, synchronous, active-high
- hash_in  input  HASH_W  digest from Keccak; sampled only on accept
- hash_valid  input  1  digest available
- hash_ready  output  1  block can accept a digest
- base_addr  input  32  byte base of the digest area; sampled on accept
- write_addr_offset  output  32  byte address of the current beat
- ocm_data_in  output  DATA_W  write data for the current beat
- bus_write_valid  output  1  beat presented
- bus_write_ready  input  1  bus accepts beat
- bus_write_last  output  1  current beat is the final beat of the digest
- done  output  1  one-cycle pulse after the last beat is accepted
- hash_count  output  16  number of digests fully written since reset

## Operation
- States: IDLE, SEND, DONE.
- IDLE: hash_ready=1, bus_write_valid=0. On hash_valid && hash_ready: capture hash_in into hash_buf and base_addr into base_buf, clear beat_cnt, go to SEND.
- SEND: bus_write_valid=1. ocm_data_in = hash_buf[DATA_W*beat_cnt +: DATA_W] (beat 0 = bits 127:0, beat 3 = bits 511:384). write_addr_offset = base_buf + 64*hash_count + 16*beat_cnt, 32-bit modular add, no saturation. bus_write_last = (beat_cnt == BEATS-1).
- A beat transfers on a cycle with bus_write_valid && bus_write_ready. On transfer: if not the last beat, beat_cnt++ and stay in SEND; on the last beat go to DONE.
- While valid && !ready, ocm_data_in, write_addr_offset and bus_write_last hold stable. valid is never withdrawn before the transfer.
- DONE: done=1 for exactly this cycle, hash_count++ (16-bit, wraps 0xFFFF->0x0000), return to IDLE. hash_ready=0 in SEND and DONE.
- hash_valid in SEND/DONE is ignored. The producer holds it until hash_ready is seen.
- hash_in changing after accept has no effect on the beats being written.

## Timing
- Reset values (register outputs, sampled reset at clock edge): state=IDLE, hash_ready=1, bus_write_valid=0, bus_write_last=0, done=0, ocm_data_in=0, write_addr_offset=0, hash_count=0, beat_cnt=0, hash_buf=0.
- Reset mid-SEND: the in-flight digest is abandoned. From the next cycle valid=0, hash_count is unchanged from 0 (it is reset), and no done pulse occurs.
- Accept at edge N -> first beat valid from cycle N+1.
- With ready held high: beats on cycles N+1..N+4, last on N+4, done on N+5, hash_ready=1 again on N+6. Minimum 6 cycles per digest.
- Each cycle of ready low adds one cycle. There is no timeout.
- hash_count updates on the same edge that ends DONE, so it is visible together with hash_ready=1.
- All outputs are registered or decoded only from state and registers. There is no combinational path from bus_write_ready or hash_valid to any output.

## Test plan
- Single digest, ready=1: hash_in = 0x00..03_00..02_00..01_00..00 (beat i = value i), base=0x1000 -> beats 0,1,2,3 at 0x1000/0x1010/0x1020/0x1030; last only on 0x1030; done 5 cycles after accept; hash_count=1.
- Backpressure: ready toggles 1,0,0,1,0,1,1 -> each beat's data and address are held while ready=0, exactly 4 transfers in order, no duplicates.
- Back-to-back digests: hash_valid held high with two different hashes, base=0x2000 -> second digest at 0x2040..0x2070; hash_ready low from accept through DONE; hash_count=2.
- Hash overwrite: change hash_in and base_addr every cycle during SEND -> output beats match the value captured at accept.
- Reset mid-burst: assert reset after beat 1 transfers -> next cycle valid=0, hash_ready=1, hash_count=0, no done. A new digest at base 0x0 then writes 0x0..0x30.
- Wrap: preload hash_count to 0xFFFF via 65535 digests (or force), base=0xFFFFFFC0 -> address wraps modulo 2^32, hash_count wraps to 0 after DONE.
